// File: rtl/mcdf_pkg.sv
// Shared types and helpers for the MCDF packet arbiter.
// Holds the length-code decode, field widths and the arbiter FSM state type.
package mcdf_pkg;

   localparam int PRIO_W      = 2;
   localparam int LENCODE_W   = 3;
   localparam int LEN_FIELD_W = 6;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   // Codes 4..7 are reserved and saturate to the largest packet size.
   function automatic logic [LEN_FIELD_W-1:0] len_decode(input logic [LENCODE_W-1:0] code);
      case (code)
         3'd0:    len_decode = 6'd4;
         3'd1:    len_decode = 6'd8;
         3'd2:    len_decode = 6'd16;
         default: len_decode = 6'd32;
      endcase
   endfunction

endpackage

// File: rtl/mcdf_rr_prio_sel.sv
// Combinational channel selector: lowest priority value wins, ties are
// broken round-robin starting just above the last granted channel.
module mcdf_rr_prio_sel
   import mcdf_pkg::*;
#(
   parameter int NCH = 3,
   parameter int CHW = 3
) (
   input  logic [NCH-1:0]        req,
   input  logic [NCH*PRIO_W-1:0] prio,
   input  logic [CHW-1:0]        rr_ptr,
   output logic                  gnt_valid,
   output logic [CHW-1:0]        gnt_ch
);

   logic [PRIO_W-1:0] min_prio;

   always_comb begin
      min_prio = '1;
      for (int k = 0; k < NCH; k++) begin
         if (req[k] && (prio[k*PRIO_W +: PRIO_W] < min_prio)) begin
            min_prio = prio[k*PRIO_W +: PRIO_W];
         end
      end
   end

   always_comb begin
      int idx;
      gnt_valid = 1'b0;
      gnt_ch    = '0;
      idx       = 0;
      for (int i = 1; i <= NCH; i++) begin
         idx = (int'(rr_ptr) + i) % NCH;
         if (!gnt_valid && req[idx] && (prio[idx*PRIO_W +: PRIO_W] == min_prio)) begin
            gnt_valid = 1'b1;
            gnt_ch    = CHW'(idx);
         end
      end
   end

endmodule

// File: rtl/mcdf_pkt_arbiter.sv
// N-channel packet arbiter and framer: grants whole packets and streams
// them out through a single registered valid/ready word port.
//
//   state | meaning
//   IDLE  | no packet granted; arbitrate among requesting channels
//   XFER  | move words of the granted packet until its last word is loaded
module mcdf_pkt_arbiter
   import mcdf_pkg::*;
#(
   parameter int NCH  = 3,
   parameter int DW   = 32,
   parameter int CHW  = 3,
   parameter int LENW = 6
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic [NCH-1:0]           slv_req_i,
   input  logic [NCH-1:0]           slv_valid_i,
   input  logic [NCH*DW-1:0]        slv_data_i,
   input  logic [NCH*PRIO_W-1:0]    slv_prio_i,
   input  logic [NCH*LENCODE_W-1:0] slv_pkglen_i,
   output logic [NCH-1:0]           slv_ack_o,
   output logic                     fmt_valid_o,
   input  logic                     fmt_ready_i,
   output logic [DW-1:0]            fmt_data_o,
   output logic [CHW-1:0]           fmt_chid_o,
   output logic [LENW-1:0]          fmt_length_o,
   output logic                     fmt_start_o,
   output logic                     fmt_end_o,
   output logic                     busy_o
);

   state_t                state, state_nxt;
   logic [CHW-1:0]        gnt_ch;
   logic [CHW-1:0]        rr_ptr;
   logic [CHW-1:0]        sel_ch;
   logic                  sel_valid;
   logic [LENW-1:0]       pkt_len;
   logic [LENW-1:0]       cnt;
   logic                  cur_valid;
   logic [DW-1:0]         cur_data;
   logic [LENCODE_W-1:0]  sel_code;
   logic                  load;
   logic                  last;

   mcdf_rr_prio_sel #(
      .NCH (NCH),
      .CHW (CHW)
   ) u_sel (
      .req       (slv_req_i),
      .prio      (slv_prio_i),
      .rr_ptr    (rr_ptr),
      .gnt_valid (sel_valid),
      .gnt_ch    (sel_ch)
   );

   always_comb begin
      cur_valid = 1'b0;
      cur_data  = '0;
      sel_code  = '0;
      for (int k = 0; k < NCH; k++) begin
         if (gnt_ch == CHW'(k)) begin
            cur_valid = slv_valid_i[k];
            cur_data  = slv_data_i[k*DW +: DW];
         end
         if (sel_ch == CHW'(k)) begin
            sel_code = slv_pkglen_i[k*LENCODE_W +: LENCODE_W];
         end
      end
   end

   // A word may enter the output register when it is empty or draining this cycle.
   assign load = (state == XFER) && cur_valid && (!fmt_valid_o || fmt_ready_i);
   assign last = (cnt == (pkt_len - LENW'(1)));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      slv_ack_o = '0;
      case (state)
         IDLE: begin
            if (sel_valid) begin
               state_nxt = XFER;
            end
         end
         XFER: begin
            for (int k = 0; k < NCH; k++) begin
               if (load && (gnt_ch == CHW'(k))) begin
                  slv_ack_o[k] = 1'b1;
               end
            end
            if (load && last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         gnt_ch  <= '0;
         rr_ptr  <= CHW'(NCH - 1);
         pkt_len <= '0;
         cnt     <= '0;
      end else if ((state == IDLE) && sel_valid) begin
         gnt_ch  <= sel_ch;
         rr_ptr  <= sel_ch;
         pkt_len <= LENW'(len_decode(sel_code));
         cnt     <= '0;
      end else if (load) begin
         cnt <= cnt + LENW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         fmt_valid_o  <= 1'b0;
         fmt_data_o   <= '0;
         fmt_chid_o   <= '0;
         fmt_length_o <= '0;
         fmt_start_o  <= 1'b0;
         fmt_end_o    <= 1'b0;
      end else if (load) begin
         fmt_valid_o  <= 1'b1;
         fmt_data_o   <= cur_data;
         fmt_chid_o   <= gnt_ch;
         fmt_length_o <= pkt_len;
         fmt_start_o  <= (cnt == '0);
         fmt_end_o    <= last;
      end else if (fmt_ready_i) begin
         fmt_valid_o  <= 1'b0;
         fmt_start_o  <= 1'b0;
         fmt_end_o    <= 1'b0;
      end
   end

   assign busy_o = (state == XFER) || fmt_valid_o;

endmodule

// File: tb/tb_mcdf_pkt_arbiter.sv
// Scoreboard bench for mcdf_pkt_arbiter: a 3-channel/32-bit instance and a
// 5-channel/64-bit instance fed by simple FIFO-head source models.
module tb_mcdf_pkt_arbiter;

   localparam int NCH  = 3;
   localparam int DW   = 32;
   localparam int NCH2 = 5;
   localparam int DW2  = 64;
   localparam int CHW  = 3;
   localparam int LENW = 6;

   logic clk_i  = 1'b0;
   logic rstn_i = 1'b0;
   logic fr     = 1'b1;

   always #5 clk_i = ~clk_i;

   logic [NCH-1:0]    req_a, valid_a, ack_a;
   logic [NCH*DW-1:0] data_a;
   logic [NCH*2-1:0]  prio_a;
   logic [NCH*3-1:0]  code_a;
   logic              fv_a, fs_a, fe_a, busy_a;
   logic [DW-1:0]     fd_a;
   logic [CHW-1:0]    fc_a;
   logic [LENW-1:0]   fl_a;

   logic [NCH2-1:0]     req_b, valid_b, ack_b;
   logic [NCH2*DW2-1:0] data_b;
   logic [NCH2*2-1:0]   prio_b;
   logic [NCH2*3-1:0]   code_b;
   logic                fv_b, fs_b, fe_b, busy_b;
   logic [DW2-1:0]      fd_b;
   logic [CHW-1:0]      fc_b;
   logic [LENW-1:0]     fl_b;

   mcdf_pkt_arbiter #(.NCH(NCH), .DW(DW), .CHW(CHW), .LENW(LENW)) u_dut_a (
      .clk_i (clk_i), .rstn_i (rstn_i),
      .slv_req_i (req_a), .slv_valid_i (valid_a), .slv_data_i (data_a),
      .slv_prio_i (prio_a), .slv_pkglen_i (code_a), .slv_ack_o (ack_a),
      .fmt_valid_o (fv_a), .fmt_ready_i (fr), .fmt_data_o (fd_a),
      .fmt_chid_o (fc_a), .fmt_length_o (fl_a), .fmt_start_o (fs_a),
      .fmt_end_o (fe_a), .busy_o (busy_a)
   );

   mcdf_pkt_arbiter #(.NCH(NCH2), .DW(DW2), .CHW(CHW), .LENW(LENW)) u_dut_b (
      .clk_i (clk_i), .rstn_i (rstn_i),
      .slv_req_i (req_b), .slv_valid_i (valid_b), .slv_data_i (data_b),
      .slv_prio_i (prio_b), .slv_pkglen_i (code_b), .slv_ack_o (ack_b),
      .fmt_valid_o (fv_b), .fmt_ready_i (fr), .fmt_data_o (fd_b),
      .fmt_chid_o (fc_b), .fmt_length_o (fl_b), .fmt_start_o (fs_b),
      .fmt_end_o (fe_b), .busy_o (busy_b)
   );

   function automatic logic [31:0] mk32(input int k, input int s);
      return {8'(k), 24'(s)};
   endfunction

   function automatic logic [63:0] mk64(input int k, input int s);
      return {32'hC0DE_0000 | 32'(k), 32'(s)};
   endfunction

   // Source FIFO models: words pushed by the stimulus, popped by acks.
   int pushed_a[NCH]  = '{default: 0};
   int popped_a[NCH]  = '{default: 0};
   int exp_seq_a[NCH] = '{default: 0};
   int pushed_b[NCH2] = '{default: 0};
   int popped_b[NCH2] = '{default: 0};
   int exp_seq_b[NCH2] = '{default: 0};

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         req_a[k]           = pushed_a[k] > popped_a[k];
         data_a[k*DW +: DW] = mk32(k, popped_a[k]);
      end
   end
   assign valid_a = req_a;

   always_comb begin
      for (int k = 0; k < NCH2; k++) begin
         req_b[k]              = pushed_b[k] > popped_b[k];
         data_b[k*DW2 +: DW2]  = mk64(k, popped_b[k]);
      end
   end
   assign valid_b = req_b;

   always @(posedge clk_i) begin
      for (int k = 0; k < NCH; k++) begin
         if (ack_a[k]) popped_a[k] <= popped_a[k] + 1;
      end
      for (int k = 0; k < NCH2; k++) begin
         if (ack_b[k]) popped_b[k] <= popped_b[k] + 1;
      end
   end

   typedef struct {
      logic [63:0] data;
      int          ch;
      int          len;
      logic        st;
      logic        en;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   checks = 0;
   int   errors = 0;
   int   hs_a   = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic cfg_a(input int ch, input int p, input int c);
      prio_a[ch*2 +: 2] = 2'(p);
      code_a[ch*3 +: 3] = 3'(c);
   endtask

   task automatic src_a(input int ch, input int len);
      pushed_a[ch] += len;
   endtask

   task automatic exp_a(input int ch, input int len);
      exp_t e;
      for (int w = 0; w < len; w++) begin
         e.data = {32'h0, mk32(ch, exp_seq_a[ch] + w)};
         e.ch   = ch;
         e.len  = len;
         e.st   = (w == 0);
         e.en   = (w == len - 1);
         q_a.push_back(e);
      end
      exp_seq_a[ch] += len;
   endtask

   task automatic exp_b(input int ch, input int len);
      exp_t e;
      for (int w = 0; w < len; w++) begin
         e.data = mk64(ch, exp_seq_b[ch] + w);
         e.ch   = ch;
         e.len  = len;
         e.st   = (w == 0);
         e.en   = (w == len - 1);
         q_b.push_back(e);
      end
      exp_seq_b[ch] += len;
   endtask

   // Monitors: each accepted output word is popped and compared.
   initial forever begin
      exp_t e;
      @(negedge clk_i);
      if (rstn_i && fv_a && fr) begin
         hs_a++;
         checks++;
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL word_a: unexpected word data=%h chid=%0d", fd_a, fc_a);
         end else begin
            e = q_a.pop_front();
            if (fd_a !== e.data[31:0] || fc_a !== CHW'(e.ch) || fl_a !== LENW'(e.len) ||
                fs_a !== e.st || fe_a !== e.en) begin
               errors++;
               $display("FAIL word_a: got data=%h chid=%0d len=%0d st=%b en=%b, expected data=%h chid=%0d len=%0d st=%b en=%b",
                        fd_a, fc_a, fl_a, fs_a, fe_a, e.data[31:0], e.ch, e.len, e.st, e.en);
            end
         end
      end
   end

   initial forever begin
      exp_t e;
      @(negedge clk_i);
      if (rstn_i && fv_b && fr) begin
         checks++;
         if (q_b.size() == 0) begin
            errors++;
            $display("FAIL word_b: unexpected word data=%h chid=%0d", fd_b, fc_b);
         end else begin
            e = q_b.pop_front();
            if (fd_b !== e.data || fc_b !== CHW'(e.ch) || fl_b !== LENW'(e.len) ||
                fs_b !== e.st || fe_b !== e.en) begin
               errors++;
               $display("FAIL word_b: got data=%h chid=%0d len=%0d st=%b en=%b, expected data=%h chid=%0d len=%0d st=%b en=%b",
                        fd_b, fc_b, fl_b, fs_b, fe_b, e.data, e.ch, e.len, e.st, e.en);
            end
         end
      end
   end

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((q_a.size() != 0 || busy_a || q_b.size() != 0 || busy_b) && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s: timeout with %0d words still expected", name, q_a.size() + q_b.size());
      end
   endtask

   task automatic wait_hs(input string name, input int target);
      int n;
      n = 0;
      while (hs_a < target && n < 200) begin
         @(negedge clk_i);
         #1;
         n++;
      end
      checks++;
      if (hs_a < target) begin
         errors++;
         $display("FAIL %s: only %0d words accepted, wanted %0d", name, hs_a, target);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 64'(fv_a), 64'(0));
      chk({tag, "_data"},  64'(fd_a), 64'(0));
      chk({tag, "_chid"},  64'(fc_a), 64'(0));
      chk({tag, "_len"},   64'(fl_a), 64'(0));
      chk({tag, "_start"}, 64'(fs_a), 64'(0));
      chk({tag, "_end"},   64'(fe_a), 64'(0));
      chk({tag, "_ack"},   64'(ack_a), 64'(0));
      chk({tag, "_busy"},  64'(busy_a), 64'(0));
   endtask

   initial begin
      int p0, p1, p2, base;
      logic [DW-1:0] snap_d;
      logic snap_s, snap_e;
      prio_a = '0; code_a = '0; prio_b = '0; code_b = '0;
      snap_d = '0; snap_s = 1'b0; snap_e = 1'b0;

      #1;
      chk_all_zero("rst");
      chk("rst_valid_b", 64'(fv_b), 64'(0));
      repeat (3) @(posedge clk_i);
      #1 rstn_i = 1'b1;

      // Round robin from reset pointer NCH-1: order 0,1,2,0,1,2.
      @(posedge clk_i); #1;
      src_a(0, 8); src_a(1, 8); src_a(2, 8);
      exp_a(0, 4); exp_a(1, 4); exp_a(2, 4);
      exp_a(0, 4); exp_a(1, 4); exp_a(2, 4);
      drain("rr_order", 300);

      // Single channel, 4 words, with first-word latency.
      cfg_a(1, 0, 0);
      p0 = popped_a[0]; p1 = popped_a[1]; p2 = popped_a[2];
      @(posedge clk_i); #1;
      src_a(1, 4); exp_a(1, 4);
      @(posedge clk_i); #1;
      chk("lat_cycle1_valid", 64'(fv_a), 64'(0));
      @(posedge clk_i); #1;
      chk("lat_cycle2_valid", 64'(fv_a), 64'(1));
      chk("lat_cycle2_start", 64'(fs_a), 64'(1));
      drain("single_ch1", 100);
      chk("acks_ch1", 64'(popped_a[1] - p1), 64'(4));
      chk("acks_ch0", 64'(popped_a[0] - p0), 64'(0));
      chk("acks_ch2", 64'(popped_a[2] - p2), 64'(0));

      // Priority: ch2 (prio 1, 8 words) before ch0 (prio 2, 4 words).
      cfg_a(0, 2, 0); cfg_a(1, 3, 0); cfg_a(2, 1, 1);
      @(posedge clk_i); #1;
      src_a(0, 4); src_a(2, 8);
      exp_a(2, 8); exp_a(0, 4);
      drain("prio_order", 200);

      // Backpressure for 5 cycles in the middle of an 8-word packet.
      cfg_a(0, 0, 1); cfg_a(1, 0, 0); cfg_a(2, 0, 0);
      base = hs_a;
      @(posedge clk_i); #1;
      src_a(0, 8); exp_a(0, 8);
      wait_hs("stall_reach", base + 3);
      @(posedge clk_i); #1 fr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         if (i == 0) begin
            snap_d = fd_a; snap_s = fs_a; snap_e = fe_a;
         end
         chk("stall_valid", 64'(fv_a), 64'(1));
         chk("stall_hold", {fd_a, 30'(0), fs_a, fe_a}, {snap_d, 30'(0), snap_s, snap_e});
         chk("stall_ack", 64'(ack_a), 64'(0));
      end
      @(posedge clk_i); #1 fr = 1'b1;
      drain("stall_done", 100);

      // Reset mid-packet, then fresh arbitration from pointer NCH-1.
      cfg_a(1, 0, 2);
      base = hs_a;
      @(posedge clk_i); #1;
      src_a(1, 16); exp_a(1, 16);
      wait_hs("reset_reach", base + 5);
      @(posedge clk_i); #1 rstn_i = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      q_a.delete();
      for (int k = 0; k < NCH; k++) begin
         pushed_a[k]  = popped_a[k];
         exp_seq_a[k] = popped_a[k];
      end
      repeat (2) @(posedge clk_i);
      #1 rstn_i = 1'b1;
      cfg_a(0, 0, 0); cfg_a(1, 0, 0); cfg_a(2, 0, 0);
      @(posedge clk_i); #1;
      src_a(0, 4); src_a(2, 4);
      exp_a(0, 4); exp_a(2, 4);
      drain("post_reset", 100);

      // Wide instance: reserved code 7 on ch4 gives a 32-word packet.
      prio_b[4*2 +: 2] = 2'd0;
      code_b[4*3 +: 3] = 3'd7;
      @(posedge clk_i); #1;
      pushed_b[4] += 32;
      exp_b(4, 32);
      drain("wide_ch4", 200);
      chk("acks_b_ch4", 64'(popped_b[4]), 64'(32));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
